// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, credit limits and width helper for FIFO stream stages.
package fifo_pkg;
    localparam int DWIDTH_DEF  = 16;
    localparam int CREDITS_MIN = 2;
    localparam int CREDITS_MAX = 4;

    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/stream_buf.sv
// stream_buf: small circular buffer presenting its head word and occupancy.
// clr empties it synchronously; contents are kept but become unreachable.
module stream_buf
    import fifo_pkg::*;
#(
    parameter  int DWIDTH = DWIDTH_DEF,
    parameter  int DEPTH  = CREDITS_MIN,
    localparam int LW     = clog2p1(DEPTH),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [DWIDTH-1:0] dout,
    output logic [LW-1:0]     level
);
    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [LW-1:0]     r_level;
    logic              w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop = pop & (r_level != '0);
    assign dout  = r_mem[r_rd];
    assign level = r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (push)
                r_wr <= nxt(r_wr);
            if (w_pop)
                r_rd <= nxt(r_rd);
            r_level <= r_level + LW'(push) - LW'(w_pop);
        end
    end

    // Storage is cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (push && !clr) begin
            r_mem[r_wr] <= din;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !clr && !w_pop && r_level == LW'(DEPTH)))
        else $error("ERROR: stream_buf overflow");
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a synchronous FIFO read port into a valid/ready stream.
// Reads are issued only against free credits, so the buffer can never overflow.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter  int DWIDTH  = DWIDTH_DEF,
    parameter  int CREDITS = CREDITS_MIN,
    localparam int LW      = clog2p1(CREDITS),
    localparam int OW      = LW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [LW-1:0]     level
);
    logic          r_inflight;
    logic          w_pop;
    logic          w_push;
    logic [OW-1:0] w_owed;

    assign m_valid = (level != '0);
    assign w_pop   = m_valid & m_ready;
    assign w_push  = r_inflight & !flush;
    // Counting this cycle's pop as a freed credit keeps CREDITS=2 at full rate.
    assign w_owed     = {1'b0, level} + OW'(r_inflight) - OW'(w_pop);
    assign fifo_rd_en = !rst & !flush & !fifo_empty & (w_owed < OW'(CREDITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_inflight <= 1'b0;
        else
            r_inflight <= fifo_rd_en;
    end

    stream_buf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (CREDITS)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (w_push),
        .din   (fifo_dout),
        .pop   (w_pop),
        .dout  (m_data),
        .level (level)
    );

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_rd_en && fifo_empty))
        else $error("ERROR: read issued while fifo_empty");

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, level} + OW'(r_inflight)) <= OW'(CREDITS))
        else $error("ERROR: level + inflight exceeds CREDITS");

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready && !flush) |=> $stable(m_data))
        else $error("ERROR: m_data changed while valid and stalled");
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed stimulus with a scoreboard queue checked by a monitor.
module tb_fifo_rd_stream;
    localparam int DW = 16;
    localparam int CR = 2;
    localparam int LW = $clog2(CR + 1);

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          flush      = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          m_ready    = 1'b0;
    logic [DW-1:0] fifo_dout  = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [LW-1:0] level;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DWIDTH(DW), .CREDITS(CR)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level)
    );

    // Behavioural FIFO read port: registered dout, empty updated at the edge.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() != 0)
            fifo_dout <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (fifo_empty)
                check("rd_while_empty", 32'(fifo_rd_en), 32'd0);
            if (m_valid && m_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, expected no word", m_data);
                end else begin
                    check("data", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_stall = !rst && m_valid && !m_ready && !flush;
        prev_data  = m_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w, input bit expected);
        fifo_q.push_back(w);
        if (expected)
            exp_q.push_back(w);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 200) begin
            step();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] rd_exp = 8'b0000_1111;
        logic [7:0] vl_exp = 8'b0011_1100;
        int n;
        int run;
        int rd;
        for (int i = 0; i < 4; i++)
            load(16'hA001 + 16'(i), 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

        // Test 1: startup latency and drain
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t1_rd_en", 32'(fifo_rd_en), 32'(rd_exp[c]));
            check("t1_valid", 32'(m_valid), 32'(vl_exp[c]));
            if (c == 2)
                check("t1_first_data", 32'(m_data), 32'hA001);
        end
        step();
        drain("t1_drain");

        // Test 2: full throughput
        for (int i = 0; i < 16; i++)
            load(16'h2000 + 16'(i), 1'b1);
        n = 0;
        while (!m_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t2_start", 32'(m_valid), 32'd1);
        run = 0;
        while (m_valid && run < 40) begin
            run++;
            @(negedge clk);
        end
        check("t2_run", 32'(run), 32'd16);
        step();
        drain("t2_drain");

        // Test 3: backpressure
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            load(16'hF000 + 16'(i), 1'b1);
        rd = 0;
        repeat (10) begin
            @(negedge clk);
            rd += int'(fifo_rd_en);
        end
        check("t3_reads", 32'(rd), 32'd2);
        check("t3_level", 32'(level), 32'd2);
        check("t3_data", 32'(m_data), 32'hF000);
        step();
        m_ready = 1'b1;
        drain("t3_drain");

        // Test 4: toggling ready
        for (int i = 0; i < 16; i++)
            load(16'hB000 + 16'(i), 1'b1);
        for (int i = 0; i < 40; i++) begin
            m_ready = ~m_ready;
            step();
        end
        m_ready = 1'b1;
        drain("t4_drain");

        // Test 5: flush with one word buffered and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            load(16'hC001 + 16'(i), (i == 0) || (i >= 3));
        n = 0;
        while (level != 2 && n < 20) begin
            step();
            n++;
        end
        check("t5_fill", 32'(level), 32'd2);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        flush   = 1'b1;
        check("t5_level_pre", 32'(level), 32'd1);
        @(negedge clk);
        check("t5_rd_flush", 32'(fifo_rd_en), 32'd0);
        step();
        flush = 1'b0;
        check("t5_valid", 32'(m_valid), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        m_ready = 1'b1;
        drain("t5_drain");

        // Test 6: asynchronous reset mid-burst
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            load(16'hD000 + 16'(i), 1'b0);
        repeat (5) step();
        check("t6_level_pre", 32'(level), 32'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(m_valid), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_rd_en", 32'(fifo_rd_en), 32'd0);
        fifo_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_level_rel", 32'(level), 32'd0);
        for (int i = 0; i < 4; i++)
            load(16'hE000 + 16'(i), 1'b1);
        m_ready = 1'b1;
        repeat (2) step();
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end
endmodule
